// File: rtl/rv32imc_types.sv
// Shared types for the memory-side blocks of the rv32imc core.
package rv32imc_types;

  // Arbitration policy for multi-requestor memory ports
  typedef enum logic {
    ARB_FIXED = 1'b0,  // lowest index wins
    ARB_RR    = 1'b1   // round-robin starting after the last winner
  } arb_mode_t;

endpackage

// File: rtl/mem_arbiter_arb_picker.sv
// Combinational winner selection: one-hot grant from a request vector.
// The search starts at start_i (round-robin) or at 0 (fixed) and wraps.
module arb_picker
  import rv32imc_types::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] start_i,
  input  arb_mode_t                 mode_i,
  output logic [NUM_CH-1:0]         grant_o
);

  localparam int unsigned PW = $clog2(NUM_CH);

  logic [PW-1:0] base;
  logic [PW:0]   slot;
  logic          found;

  // Walk the channels from the start point, modulo NUM_CH, taking the first requester
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    slot    = '0;
    base    = (mode_i == ARB_FIXED) ? '0 : start_i;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      slot = {1'b0, base} + (PW+1)'(i);
      if (slot >= (PW+1)'(NUM_CH)) slot = slot - (PW+1)'(NUM_CH);
      if (!found && req_i[slot[PW-1:0]]) begin
        grant_o[slot[PW-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel to single-port memory arbiter. One outstanding transaction;
// a grant is taken only from IDLE, so transactions are separated by an idle cycle.
module mem_arbiter
  import rv32imc_types::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter arb_mode_t   ARB_MODE = ARB_RR,
  localparam int unsigned MASK_W  = DATA_W / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0][MASK_W-1:0]  ch_rmask,
  input  logic [NUM_CH-1:0][MASK_W-1:0]  ch_wmask,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0][DATA_W-1:0]  ch_rdata,
  output logic [NUM_CH-1:0]              ch_resp,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [MASK_W-1:0]              mem_rmask,
  output logic [MASK_W-1:0]              mem_wmask,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_resp,
  output logic [NUM_CH-1:0]              o_grant,
  output logic                           o_busy
);

  localparam int unsigned PW = $clog2(NUM_CH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t state_q, state_d;

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MASK_W-1:0] rmask_q, rmask_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pick;
  logic              any_req;
  logic [PW-1:0]     win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [MASK_W-1:0] win_rmask;
  logic [MASK_W-1:0] win_wmask;
  logic [DATA_W-1:0] win_wdata;

  // A channel requests whenever either byte mask is nonzero
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req[i] = |(ch_rmask[i] | ch_wmask[i]);
    end
    any_req = |req;
  end

  arb_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req_i   (req),
    .start_i (rr_ptr_q),
    .mode_i  (ARB_MODE),
    .grant_o (pick)
  );

  // Mux the winning channel's request fields and encode its index
  always_comb begin
    win_idx   = '0;
    win_addr  = '0;
    win_rmask = '0;
    win_wmask = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pick[i]) begin
        win_idx   = PW'(i);
        win_addr  = ch_addr[i];
        win_rmask = ch_rmask[i];
        win_wmask = ch_wmask[i];
        win_wdata = ch_wdata[i];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: grant from IDLE, complete on mem_resp from BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_req)  state_d = S_BUSY;
      S_BUSY: if (mem_resp) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture winner on grant, drop masks/grant on completion
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    rmask_d  = rmask_q;
    wmask_d  = wmask_q;
    wdata_d  = wdata_q;
    if (state_q == S_IDLE && any_req) begin
      grant_d  = pick;
      addr_d   = win_addr;
      rmask_d  = win_rmask;
      wmask_d  = win_wmask;
      wdata_d  = win_wdata;
      rr_ptr_d = (win_idx == PW'(NUM_CH - 1)) ? '0 : win_idx + PW'(1);
    end else if (state_q == S_BUSY && mem_resp) begin
      grant_d = '0;
      rmask_d = '0;
      wmask_d = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      rmask_q  <= '0;
      wmask_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      rmask_q  <= rmask_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
    end
  end

  // FSM outputs: completion is routed combinationally to the owner only
  always_comb begin
    o_busy   = (state_q == S_BUSY);
    ch_resp  = (o_busy && mem_resp && !rst) ? grant_q : '0;
    ch_rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_resp[i]) ch_rdata[i] = mem_rdata;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rmask = rmask_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign o_grant   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on a 2-channel round-robin
// instance and a 4-channel fixed-priority instance, then randomized traffic
// on the fixed-priority instance against a transaction-level model.
module tb_mem_arbiter;
  import rv32imc_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] RD_KEY = 32'hC3C3_3C3C;

  // instance A: 2 channels, round-robin
  logic                  a_rst;
  logic [1:0][31:0]      a_ch_addr, a_ch_wdata, a_ch_rdata;
  logic [1:0][3:0]       a_ch_rmask, a_ch_wmask;
  logic [1:0]            a_ch_resp, a_grant;
  logic [31:0]           a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]            a_mem_rmask, a_mem_wmask;
  logic                  a_mem_resp, a_busy;

  // instance B: 4 channels, fixed priority
  logic                  b_rst;
  logic [3:0][31:0]      b_ch_addr, b_ch_wdata, b_ch_rdata;
  logic [3:0][3:0]       b_ch_rmask, b_ch_wmask;
  logic [3:0]            b_ch_resp, b_grant;
  logic [31:0]           b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]            b_mem_rmask, b_mem_wmask;
  logic                  b_mem_resp, b_busy;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_RR)) u_a (
    .clk(clk), .rst(a_rst),
    .ch_addr(a_ch_addr), .ch_rmask(a_ch_rmask), .ch_wmask(a_ch_wmask),
    .ch_wdata(a_ch_wdata), .ch_rdata(a_ch_rdata), .ch_resp(a_ch_resp),
    .mem_addr(a_mem_addr), .mem_rmask(a_mem_rmask), .mem_wmask(a_mem_wmask),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp),
    .o_grant(a_grant), .o_busy(a_busy)
  );

  mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_FIXED)) u_b (
    .clk(clk), .rst(b_rst),
    .ch_addr(b_ch_addr), .ch_rmask(b_ch_rmask), .ch_wmask(b_ch_wmask),
    .ch_wdata(b_ch_wdata), .ch_rdata(b_ch_rdata), .ch_resp(b_ch_resp),
    .mem_addr(b_mem_addr), .mem_rmask(b_mem_rmask), .mem_wmask(b_mem_wmask),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp),
    .o_grant(b_grant), .o_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive point: just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sample point: falling edge, combinational outputs settled
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // random-phase model state
  logic [3:0]  act, done;
  logic [31:0] r_addr  [4];
  logic [31:0] r_wdata [4];
  logic [3:0]  r_rm    [4];
  logic [3:0]  r_wm    [4];
  bit          mdl_busy, nxt_busy;
  int          mdl_owner, nxt_owner, lat;

  initial begin
    int exp_ptr;
    int n_grants;
    int order[$];
    logic [3:0] drop;

    a_rst = 1'b1; b_rst = 1'b1;
    a_ch_addr = '0; a_ch_rmask = '0; a_ch_wmask = '0; a_ch_wdata = '0;
    b_ch_addr = '0; b_ch_rmask = '0; b_ch_wmask = '0; b_ch_wdata = '0;
    a_mem_rdata = '0; a_mem_resp = 1'b0;
    b_mem_rdata = '0; b_mem_resp = 1'b0;

    // ---- reset values, with requests and mem_resp present during reset
    step();
    a_ch_rmask[0] = 4'hF; b_ch_wmask[2] = 4'h1; a_mem_resp = 1'b1; b_mem_resp = 1'b1;
    step();
    smp();
    chk("rst_a_busy",  a_busy, 0);       chk("rst_a_grant", a_grant, 0);
    chk("rst_a_resp",  a_ch_resp, 0);    chk("rst_a_rmask", a_mem_rmask, 0);
    chk("rst_a_wmask", a_mem_wmask, 0);  chk("rst_a_addr",  a_mem_addr, 0);
    chk("rst_a_wdata", a_mem_wdata, 0);
    chk("rst_b_busy",  b_busy, 0);       chk("rst_b_grant", b_grant, 0);
    chk("rst_b_resp",  b_ch_resp, 0);    chk("rst_b_wmask", b_mem_wmask, 0);
    chk("rst_b_addr",  b_mem_addr, 0);   chk("rst_b_wdata", b_mem_wdata, 0);

    step();
    a_rst = 1'b0; b_rst = 1'b0;
    a_ch_rmask = '0; b_ch_wmask = '0; a_mem_resp = 1'b0; b_mem_resp = 1'b0;

    // ---- single read on A: request cycle 0, response cycle 3
    step();
    a_ch_addr[0] = 32'h100; a_ch_rmask[0] = 4'hF;
    smp();
    chk("rd_c0_busy", a_busy, 0);
    chk("rd_c0_rmask", a_mem_rmask, 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin a_mem_resp = 1'b1; a_mem_rdata = 32'hDEADBEEF; end
      smp();
      chk($sformatf("rd_c%0d_rmask", c), a_mem_rmask, 4'hF);
      chk($sformatf("rd_c%0d_addr", c), a_mem_addr, 32'h100);
      chk($sformatf("rd_c%0d_grant", c), a_grant, 2'b01);
      chk($sformatf("rd_c%0d_busy", c), a_busy, 1);
      chk($sformatf("rd_c%0d_resp", c), a_ch_resp, (c == 3) ? 2'b01 : 2'b00);
    end
    chk("rd_c3_rdata", a_ch_rdata[0], 32'hDEADBEEF);
    step();
    a_mem_resp = 1'b0; a_ch_rmask[0] = 4'h0;
    smp();
    chk("rd_c4_busy", a_busy, 0);
    chk("rd_c4_grant", a_grant, 0);
    chk("rd_c4_rmask", a_mem_rmask, 0);
    chk("rd_c4_resp", a_ch_resp, 0);
    exp_ptr = 1;  // channel 0 just won

    // ---- round-robin with both channels requesting, single-cycle memory
    step();
    a_ch_addr[0] = 32'h10; a_ch_rmask[0] = 4'hF;
    a_ch_addr[1] = 32'h20; a_ch_rmask[1] = 4'hF;
    n_grants = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      a_mem_resp = a_busy;
      smp();
      if (a_busy) begin
        chk($sformatf("rr_grant_%0d", n_grants), a_grant, 32'(1) << exp_ptr);
        chk($sformatf("rr_resp_%0d", n_grants), a_ch_resp, 32'(1) << exp_ptr);
        chk($sformatf("rr_addr_%0d", n_grants), a_mem_addr, (exp_ptr == 0) ? 32'h10 : 32'h20);
        exp_ptr = (exp_ptr + 1) % 2;
        n_grants++;
      end
    end
    chk("rr_grant_count", n_grants, 8);
    // the last idle cycle already issued another grant; drain it while dropping requests
    step();
    a_mem_resp = 1'b1; a_ch_rmask = '0;
    smp();
    chk("rr_drain_grant", a_grant, 32'(1) << exp_ptr);
    chk("rr_drain_resp", a_ch_resp, 32'(1) << exp_ptr);
    exp_ptr = (exp_ptr + 1) % 2;
    step();
    a_mem_resp = 1'b0;

    // ---- mem_resp while idle is ignored
    step();
    a_mem_resp = 1'b1; a_mem_rdata = 32'h5555AAAA;
    smp();
    chk("idle_resp_resp", a_ch_resp, 0);
    chk("idle_resp_grant", a_grant, 0);
    chk("idle_resp_busy", a_busy, 0);
    step();
    a_mem_resp = 1'b0;
    smp();
    chk("idle_resp_after_busy", a_busy, 0);
    chk("idle_resp_after_resp", a_ch_resp, 0);

    // ---- reset while busy abandons the transaction (ch0 wins, pointer moves to 1)
    step();
    a_ch_addr[0] = 32'h300; a_ch_wmask[0] = 4'hC; a_ch_wdata[0] = 32'h12345678;
    step();
    smp();
    chk("abort_busy", a_busy, 1);
    chk("abort_grant", a_grant, 2'b01);
    step();
    a_rst = 1'b1; a_ch_wmask[0] = 4'h0;
    smp();
    chk("abort_rst_resp", a_ch_resp, 0);
    step();
    a_rst = 1'b0; a_mem_resp = 1'b1;
    smp();
    chk("abort_post_resp",  a_ch_resp, 0);
    chk("abort_post_busy",  a_busy, 0);
    chk("abort_post_grant", a_grant, 0);
    chk("abort_post_rmask", a_mem_rmask, 0);
    chk("abort_post_wmask", a_mem_wmask, 0);
    chk("abort_post_addr",  a_mem_addr, 0);
    chk("abort_post_wdata", a_mem_wdata, 0);
    // reset returned the pointer to 0, so ch0 wins a tie again
    step();
    a_mem_resp = 1'b0; a_ch_rmask[0] = 4'hF; a_ch_rmask[1] = 4'hF;
    step();
    smp();
    chk("abort_ptr_reset", a_grant, 2'b01);
    step();
    a_mem_resp = 1'b1; a_ch_rmask = '0;
    step();
    a_mem_resp = 1'b0;

    // ---- fixed priority on B: ch1 and ch3 together, ch1 first
    step();
    b_ch_addr[1] = 32'h1000; b_ch_rmask[1] = 4'hF;
    b_ch_addr[3] = 32'h3000; b_ch_wmask[3] = 4'hF; b_ch_wdata[3] = 32'hCAFE0003;
    drop = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      for (int i = 0; i < 4; i++) if (drop[i]) begin b_ch_rmask[i] = '0; b_ch_wmask[i] = '0; end
      drop = '0;
      b_mem_resp = b_busy;
      smp();
      for (int i = 0; i < 4; i++) if (b_ch_resp[i]) begin order.push_back(i); drop[i] = 1'b1; end
    end
    chk("fix_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("fix_first", order[0], 1);
      chk("fix_second", order[1], 3);
    end
    step();
    b_mem_resp = 1'b0; b_ch_rmask = '0; b_ch_wmask = '0;

    // ---- write on B ch2
    step();
    b_ch_addr[2] = 32'h200; b_ch_wmask[2] = 4'h3; b_ch_wdata[2] = 32'h0000ABCD;
    step();
    smp();
    chk("wr_wmask", b_mem_wmask, 4'h3);
    chk("wr_rmask", b_mem_rmask, 4'h0);
    chk("wr_wdata", b_mem_wdata, 32'h0000ABCD);
    chk("wr_addr",  b_mem_addr, 32'h200);
    chk("wr_grant", b_grant, 4'b0100);
    step();
    b_mem_resp = 1'b1;
    smp();
    chk("wr_resp", b_ch_resp, 4'b0100);
    step();
    b_mem_resp = 1'b0; b_ch_wmask[2] = 4'h0;
    smp();
    chk("wr_done_busy", b_busy, 0);

    // ---- requestor drops its mask while granted; transaction still completes
    step();
    b_ch_addr[0] = 32'h40; b_ch_rmask[0] = 4'h6;
    step();
    step();
    b_ch_rmask[0] = 4'h0;
    smp();
    chk("drop_busy", b_busy, 1);
    chk("drop_rmask_held", b_mem_rmask, 4'h6);
    step();
    b_mem_resp = 1'b1; b_mem_rdata = 32'h0BADF00D;
    smp();
    chk("drop_resp", b_ch_resp, 4'b0001);
    chk("drop_rdata", b_ch_rdata[0], 32'h0BADF00D);
    step();
    b_mem_resp = 1'b0;

    // ---- randomized traffic on B against a transaction-level model
    act = '0; done = '0; nxt_busy = 1'b0; nxt_owner = 0; lat = 0;
    for (int i = 0; i < 4; i++) begin r_addr[i] = '0; r_wdata[i] = '0; r_rm[i] = '0; r_wm[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      mdl_busy  = nxt_busy;
      mdl_owner = nxt_owner;
      for (int i = 0; i < 4; i++) if (done[i]) act[i] = 1'b0;
      done = '0;
      for (int i = 0; i < 4; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i]     = 1'b1;
          r_addr[i]  = $urandom;
          r_wdata[i] = $urandom;
          if ($urandom_range(0, 1) == 1) begin
            r_rm[i] = 4'($urandom_range(1, 15)); r_wm[i] = 4'h0;
          end else begin
            r_rm[i] = 4'h0; r_wm[i] = 4'($urandom_range(1, 15));
          end
        end
        b_ch_addr[i]  = r_addr[i];
        b_ch_wdata[i] = r_wdata[i];
        b_ch_rmask[i] = act[i] ? r_rm[i] : 4'h0;
        b_ch_wmask[i] = act[i] ? r_wm[i] : 4'h0;
      end
      b_mem_resp = 1'b0;
      if (mdl_busy) begin
        if (lat == 0) begin b_mem_resp = 1'b1; b_mem_rdata = b_mem_addr ^ RD_KEY; end
        else lat--;
      end else begin
        lat = $urandom_range(0, 2);
        if ($urandom_range(0, 7) == 0) begin b_mem_resp = 1'b1; b_mem_rdata = $urandom; end
      end
      smp();
      chk("rnd_busy", b_busy, mdl_busy);
      chk("rnd_grant", b_grant, mdl_busy ? (32'(1) << mdl_owner) : 32'(0));
      chk("rnd_resp", b_ch_resp, (mdl_busy && b_mem_resp) ? (32'(1) << mdl_owner) : 32'(0));
      if (mdl_busy) begin
        chk("rnd_addr",  b_mem_addr,  r_addr[mdl_owner]);
        chk("rnd_rmask", b_mem_rmask, r_rm[mdl_owner]);
        chk("rnd_wmask", b_mem_wmask, r_wm[mdl_owner]);
        chk("rnd_wdata", b_mem_wdata, r_wdata[mdl_owner]);
        if (b_mem_resp) chk("rnd_rdata", b_ch_rdata[mdl_owner], r_addr[mdl_owner] ^ RD_KEY);
      end else begin
        chk("rnd_idle_rmask", b_mem_rmask, 0);
        chk("rnd_idle_wmask", b_mem_wmask, 0);
      end
      if (mdl_busy) begin
        if (b_mem_resp) begin nxt_busy = 1'b0; done[mdl_owner] = 1'b1; end
        else nxt_busy = 1'b1;
      end else begin
        nxt_busy = 1'b0;
        for (int i = 3; i >= 0; i--) if (act[i]) begin nxt_busy = 1'b1; nxt_owner = i; end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of requestor channels, legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width, a multiple of 8; MASK_W = DATA_W/8.
REQ-004 Parameter ARB_MODE, default ARB_RR: arbitration mode; ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ch_addr  in  NUM_CH x ADDR_W  per-channel request address.
REQ-008 ch_rmask  in  NUM_CH x MASK_W  per-channel read byte mask; nonzero means read request.
REQ-009 ch_wmask  in  NUM_CH x MASK_W  per-channel write byte mask; nonzero means write request.
REQ-010 ch_wdata  in  NUM_CH x DATA_W  per-channel write data.
REQ-011 ch_rdata  out  NUM_CH x DATA_W  read data, valid only when the matching ch_resp is high.
REQ-012 ch_resp  out  NUM_CH  per-channel completion pulse.
REQ-013 mem_addr / mem_rmask / mem_wmask / mem_wdata  out  ADDR_W / MASK_W / MASK_W / DATA_W  downstream request.
REQ-014 mem_rdata  in  DATA_W  downstream read data.
REQ-015 mem_resp  in  1  downstream completion, one-cycle pulse.
REQ-016 o_grant  out  NUM_CH  one-hot owner of the outstanding transaction; zero when idle.
REQ-017 o_busy  out  1  high while a downstream transaction is outstanding.

Function
REQ-018 A channel is requesting when (ch_rmask | ch_wmask) != 0; the requestor holds the request stable until its ch_resp.
REQ-019 FSM states: IDLE and BUSY.
REQ-020 IDLE: if any channel is requesting, pick the winner, register its addr, rmask, wmask and wdata into the mem_* outputs, set o_grant, and go to BUSY next cycle.
REQ-021 IDLE with no channel requesting: stay in IDLE; mem_rmask = mem_wmask = 0.
REQ-022 BUSY: mem_* outputs hold constant until mem_resp.
REQ-023 BUSY with mem_resp = 1: in the same cycle, ch_resp[grant] = 1 and ch_rdata[grant] = mem_rdata (combinational path); next cycle the FSM is IDLE, mem masks = 0 and o_grant = 0.
REQ-024 ch_resp is never asserted for a non-granted channel, and never more than one bit per cycle.
REQ-025 mem_resp received in IDLE is ignored; no ch_resp is raised.
REQ-026 A new grant is evaluated only in IDLE, so at least one idle cycle separates transactions; a request cycle-0 first reaches memory in cycle 1.
REQ-027 ARB_FIXED: the lowest-indexed requesting channel wins.
REQ-028 ARB_RR: the search starts at rr_ptr and wraps modulo NUM_CH; on each grant, rr_ptr <= (winner + 1) mod NUM_CH.
REQ-029 A requestor that drops its masks while granted does not abort the transaction; it completes and ch_resp still pulses.
REQ-030 Masks are forwarded unchanged; rmask and wmask both nonzero is a requestor protocol error and is not checked.

Reset
REQ-031 On rst: FSM = IDLE, rr_ptr = 0, o_grant = 0, o_busy = 0, ch_resp = 0, mem_rmask = 0, mem_wmask = 0, mem_addr = 0, mem_wdata = 0.
REQ-032 A reset asserted mid-transaction abandons that transaction, and no ch_resp is produced for it.

Structure
REQ-033 Enum arb_mode_t {ARB_FIXED, ARB_RR} belongs in rv32imc_types; the FSM state enum stays local to the module.
REQ-034 Winner selection is one sub-module, arb_picker (request vector, start pointer and mode in; one-hot winner out; combinational).

Verification
REQ-035 NUM_CH=2, ARB_RR: ch0 reads 0x100 at cycle 0, memory responds at cycle 3 with 0xDEADBEEF -> mem_rmask=0xF during cycles 1-3, ch_resp[0]=1 and ch_rdata[0]=0xDEADBEEF at cycle 3, o_busy=0 at cycle 4.
REQ-036 ARB_RR: ch0 and ch1 both request continuously with 1-cycle memory -> grants alternate 0,1,0,1, and neither channel is granted twice in a row.
REQ-037 ARB_FIXED, NUM_CH=4: ch1 and ch3 request together -> ch1 is served first, then ch3.
REQ-038 ch2 writes wmask=0x3 with wdata 0x0000ABCD to 0x200 -> mem_wmask=0x3, mem_wdata=0x0000ABCD, mem_addr=0x200, and ch_resp[2] pulses on mem_resp.
REQ-039 rst asserted in BUSY with mem_resp arriving the next cycle -> no ch_resp, and all outputs take their reset values.
REQ-040 mem_resp pulsed in IDLE -> ch_resp stays 0 and o_grant stays 0.
